// File: rtl/key_search_scheduler.sv
// key_search_scheduler: dynamic key dispatcher for the RC4 brute-force datapath.
// A shared key counter feeds NUM_CORES decrypt cores; any core that completes
// with failure is handed the next untried key. The first successful key and
// its core index are latched; exhaustion is flagged once every key below
// KEY_LIMIT has failed.
// Optional feature macro: KEY_SEARCH_PERF_EN (search-duration cycle counter).
module key_search_scheduler #(
  parameter int     NUM_CORES = 4,
  parameter int     KEY_WIDTH = 24,
  parameter longint KEY_LIMIT = 4194304,
  parameter longint START_KEY = 0,
  parameter int     IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_success,
  output logic                           busy,
  output logic                           found,
  output logic                           exhausted,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [IDX_W-1:0]               found_core,
  output logic [KEY_WIDTH:0]             keys_issued,
  output logic [31:0]                    cycle_count,
  output logic [9:0]                     LEDR
);

  // One extra bit so KEY_LIMIT == 2^KEY_WIDTH compares without wrapping.
  localparam logic [KEY_WIDTH:0] LIMIT_W = (KEY_WIDTH+1)'(KEY_LIMIT);
  localparam logic [KEY_WIDTH:0] START_W = (KEY_WIDTH+1)'(START_KEY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FOUND,
    S_FAIL
  } state_t;

  state_t                 state;
  logic [NUM_CORES-1:0]   core_busy;
  logic [KEY_WIDTH:0]     next_key;

  logic                   succ_hit;
  logic [IDX_W-1:0]       succ_idx;
  logic [KEY_WIDTH-1:0]   succ_key;
  logic                   free_hit;
  logic [NUM_CORES-1:0]   free_onehot;
  logic [NUM_CORES-1:0]   busy_after;
  logic                   dispatch_en;

  // Priority pick of the lowest successful busy core and the lowest idle core.
  // The idle pick uses the registered busy flags, so a core that reports
  // failure on this edge is only re-dispatched on the following edge.
  always_comb begin
    succ_hit    = 1'b0;
    succ_idx    = '0;
    succ_key    = '0;
    free_hit    = 1'b0;
    free_onehot = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!succ_hit && core_done[i] && core_success[i] && core_busy[i]) begin
        succ_hit = 1'b1;
        succ_idx = IDX_W'(i);
        succ_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
      if (!free_hit && !core_busy[i]) begin
        free_hit       = 1'b1;
        free_onehot[i] = 1'b1;
      end
    end
    busy_after  = core_busy & ~core_done;
    dispatch_en = free_hit && (next_key < LIMIT_W);
  end

  // Search FSM: dispatch, success capture, exhaustion detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      core_start  <= '0;
      core_key    <= '0;
      core_busy   <= '0;
      next_key    <= START_W;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      found_key   <= '0;
      found_core  <= '0;
      keys_issued <= '0;
    end else begin
      core_start <= '0;
      case (state)
        S_RUN: begin
          if (succ_hit) begin
            state      <= S_FOUND;
            busy       <= 1'b0;
            found      <= 1'b1;
            found_key  <= succ_key;
            found_core <= succ_idx;
          end else begin
            core_busy <= busy_after | (dispatch_en ? free_onehot : '0);
            if (dispatch_en) begin
              core_start <= free_onehot;
              for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (free_onehot[i]) begin
                  core_key[i*KEY_WIDTH +: KEY_WIDTH] <= next_key[KEY_WIDTH-1:0];
                end
              end
              next_key    <= next_key + (KEY_WIDTH+1)'(1);
              keys_issued <= keys_issued + (KEY_WIDTH+1)'(1);
            end
            if ((next_key == LIMIT_W) && (core_busy == '0)) begin
              state     <= S_FAIL;
              busy      <= 1'b0;
              exhausted <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE keeps the search context clear; FOUND/FAIL hold until start.
          if ((state == S_IDLE) || start) begin
            found       <= 1'b0;
            exhausted   <= 1'b0;
            keys_issued <= '0;
            next_key    <= START_W;
          end
          if (start) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            core_busy  <= '0;
            found_key  <= '0;
            found_core <= '0;
          end
        end
      endcase
    end
  end

`ifdef KEY_SEARCH_PERF_EN
  // Search duration: cleared by the start that enters RUN, counts RUN cycles,
  // frozen outside RUN, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if ((state != S_RUN) && start) begin
      cycle_count <= '0;
    end else if ((state == S_RUN) && (cycle_count != '1)) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`else
  assign cycle_count = '0;
`endif

  assign LEDR = {7'b0, exhausted, found, busy};

endmodule

// File: doc/key_search_scheduler.md
Name: key_search_scheduler

Overview:
- Parametrised successor to the fixed 4-way key-search controller, for the RC4 brute-force datapath.
- Owns a shared key counter and hands keys dynamically to NUM_CORES decrypt cores: any core that finishes with failure gets the next untried key, with no fixed stride.
- Latches the first successful key and its core index, and flags exhaustion once every key below KEY_LIMIT has failed.
- Sits between the top-level switches/LEDs and the array of decrypt cores.

Parameters:
- NUM_CORES, 4, number of decrypt cores; must be ≥1.
- KEY_WIDTH, 24, key width in bits.
- KEY_LIMIT, 4194304, exclusive upper bound of the key space (2^22); must be ≤2^KEY_WIDTH.
- START_KEY, 0, first key issued; must be <KEY_LIMIT.
- IDX_W, max(1,$clog2(NUM_CORES)), width of the core index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a search from IDLE, FOUND or FAIL.
- core_start  out  NUM_CORES  per-core one-cycle dispatch pulse.
- core_key  out  NUM_CORES*KEY_WIDTH  per-core key; slice i = bits [i*KEY_WIDTH +: KEY_WIDTH]; held stable between dispatches.
- core_done  in  NUM_CORES  per-core one-cycle completion pulse.
- core_success  in  NUM_CORES  qualifies core_done; 1 = key decrypted valid text.
- busy  out  1  high in RUN.
- found  out  1  sticky success flag.
- exhausted  out  1  sticky total-failure flag.
- found_key  out  KEY_WIDTH  successful key.
- found_core  out  IDX_W  index of the successful core.
- keys_issued  out  KEY_WIDTH+1  count of dispatches since start.
- cycle_count  out  32  search duration (see Optional Feature).
- LEDR  out  10  [0]=busy, [1]=found, [2]=exhausted, others 0.

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE. All outputs 0, including core_start, core_key, found_key, found_core, keys_issued, cycle_count and LEDR. Per-core busy flags cleared. next_key=START_KEY.
- States: IDLE, RUN, FOUND, FAIL.
- IDLE:
  - start → RUN.
  - Clear found/exhausted/keys_issued; next_key=START_KEY.
- RUN, evaluated each edge in this order:
  1. Success check: if any i has core_done[i] && core_success[i] && busy[i], take the lowest such i (lowest index wins on simultaneous success). Set found_key=core_key slice i, found_core=i, found=1, then → FOUND. No dispatch in this cycle.
  2. Completion: for each i with core_done[i] && busy[i], clear busy[i].
  3. Dispatch: if next_key<KEY_LIMIT, take the lowest-index core with registered busy=0. Pulse its core_start, load its core_key slice with next_key, set busy=1, increment next_key and keys_issued. At most one dispatch per cycle.
  4. Exhaustion: if next_key==KEY_LIMIT and all busy=0 and no done pending → FAIL, exhausted=1.
- Latency:
  - First core_start occurs on the first edge in RUN (core 0, START_KEY).
  - Core i first receives START_KEY+i at RUN cycle i.
  - Re-dispatch comes no earlier than the edge after the failing core_done is sampled.
- core_done on a non-busy core is ignored. core_success without core_done is ignored.
- start in RUN is ignored.
- FOUND and FAIL hold their outputs, issue no dispatches and ignore core_done.
  - start re-enters RUN: flags cleared, fresh search, busy flags cleared.
- In-flight cores at FOUND are abandoned; their later core_done is ignored.
- Reset mid-RUN aborts immediately; no further core_start.
- next_key has KEY_WIDTH+1 bits so that KEY_LIMIT=2^KEY_WIDTH compares without wrap.

Optional Feature:
- Macro KEY_SEARCH_PERF_EN.
- Defined: cycle_count clears on the start that enters RUN and increments every RUN cycle. It freezes in FOUND/FAIL and saturates at 2^32-1.
- Undefined: no counter logic is built; cycle_count is tied to 0.

Test Plan:
- NUM_CORES=4, KEY_LIMIT=16, cores return done/failure 3 cycles after core_start → keys 0..15 each dispatched exactly once; exhausted=1, LEDR=10'd4, keys_issued=16, found=0.
- Same setup, core receiving key 5 returns success → found=1, found_key=5, found_core=index that got key 5, LEDR=10'd2; no core_start after the FOUND edge.
- Cores 2 and 3 return success in the same cycle (keys 2, 3) → found_core=2, found_key=2.
- core_done pulsed on idle core 1 before any dispatch to it → no state change, keys_issued unchanged.
- reset asserted mid-RUN with keys_issued=7 → next cycle IDLE, all outputs 0; a following start redispatches key 0 to core 0.
- KEY_SEARCH_PERF_EN defined, success found after 20 RUN cycles → cycle_count=20 and held; undefined → cycle_count=0 throughout.
